dft_mac_engine: RTL

Parametrised successor of the single-bin direct-DFT datapath. It computes LANES frequency bins concurrently from one shared sample buffer, using valid/ready streams for sample input and bin output. Twiddles come from an external ROM through index/data ports. The block sits between the AXI bridge and the twiddle ROM, replacing the fixed 16-bit, one-bin datapath.

---
 rtl/dft_pkg.sv | 49 ++++
 rtl/dft_lane.sv | 58 +++++
 rtl/dft_mac_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dft_pkg.sv
// Shared types and arithmetic helpers
// for the multi-lane direct-DFT engine.
package dft_pkg;

    localparam int LANES_MAX = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        FLUSH,
        DRAIN,
        FINISH
    } state_t;

    function automatic logic signed [63:0] round_q(
        input logic signed [63:0] prod,
        input int unsigned        sh
    );
        logic signed [63:0] half;
        half = 64'sd1 <<< (sh - 1);
        return (prod + half) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat(
        input logic signed [63:0] v,
        input int unsigned        w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic int re_off(input int lane, input int w);
        return (2 * lane + 1) * w;
    endfunction

    function automatic int im_off(input int lane, input int w);
        return 2 * lane * w;
    endfunction

endpackage

// File: rtl/dft_lane.sv
// One bin lane: complex-by-real multiply,
// rounding and sticky saturating accumulate.
module dft_lane
    import dft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     n_Reset,
    input  logic                     clr,
    input  logic                     ce,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] tw_re,
    input  logic signed [DATA_W-1:0] tw_im,
    output logic signed [ACC_W-1:0]  acc_re,
    output logic signed [ACC_W-1:0]  acc_im
);

    localparam logic signed [ACC_W-1:0] ACC_MAX =
        {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] p_re;
    logic signed [2*DATA_W-1:0] p_im;
    logic signed [63:0]         s_re;
    logic signed [63:0]         s_im;
    logic signed [ACC_W-1:0]    nx_re;
    logic signed [ACC_W-1:0]    nx_im;

    // Next accumulator value; a value at either rail holds there.
    always_comb begin
        p_re  = x * tw_re;
        p_im  = x * tw_im;
        s_re  = sat(64'(acc_re) + round_q(64'(p_re), DATA_W - 1), ACC_W);
        s_im  = sat(64'(acc_im) + round_q(64'(p_im), DATA_W - 1), ACC_W);
        nx_re = (acc_re == ACC_MAX || acc_re == ACC_MIN) ?
                acc_re : s_re[ACC_W-1:0];
        nx_im = (acc_im == ACC_MAX || acc_im == ACC_MIN) ?
                acc_im : s_im[ACC_W-1:0];
    end

    // Accumulator registers with clear taking priority over enable.
    always_ff @(posedge clk) begin
        if (!n_Reset) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (clr) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (ce) begin
            acc_re <= nx_re;
            acc_im <= nx_im;
        end
    end

endmodule

// File: rtl/dft_mac_engine.sv
// Multi-lane direct DFT: buffers N samples, then
// computes LANES bins per pass over the buffer.
module dft_mac_engine
    import dft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int MAX_N  = 4096,
    parameter int LANES  = 2,
    parameter int ADDR_W = $clog2(MAX_N)
) (
    input  logic                      clk,
    input  logic                      n_Reset,
    input  logic                      start,
    input  logic [ADDR_W:0]           samp_number,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    output logic [ADDR_W-1:0]         tw_n_idx,
    output logic [LANES*ADDR_W-1:0]   tw_k_idx,
    input  logic [LANES*2*DATA_W-1:0] tw_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [2*DATA_W-1:0]       m_data,
    output logic [ADDR_W-1:0]         m_bin,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] N_MAX   = CW'(MAX_N);
    localparam logic [CW-1:0] N_LANES = CW'(LANES);

    state_t state;
    state_t state_nx;

    logic [CW-1:0]     n_len;
    logic [CW-1:0]     k0;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] n_idx;
    logic [LW-1:0]     lane;
    logic              rej_q;
    logic              mac_en;
    logic              acc_clr;

    logic [DATA_W-1:0]          mem [MAX_N];
    logic signed [DATA_W-1:0]   x_q;
    logic [LANES*2*DATA_W-1:0]  tw_q;
    logic signed [ACC_W-1:0]    acc_re [LANES];
    logic signed [ACC_W-1:0]    acc_im [LANES];

    logic          start_ok;
    logic          s_acc;
    logic          load_last;
    logic          n_last;
    logic [CW-1:0] k_cur;
    logic          out_acc;
    logic          lane_end;
    logic          grp_more;
    logic signed [63:0] o_re;
    logic signed [63:0] o_im;

    assign start_ok  = start && (samp_number >= CW'(2)) &&
                       (samp_number <= N_MAX);
    assign s_acc     = s_valid && (state == LOAD);
    assign load_last = s_acc && ({1'b0, wr_idx} == n_len - CW'(1));
    assign n_last    = ({1'b0, n_idx} == n_len - CW'(1));
    assign k_cur     = k0 + CW'(lane);
    assign out_acc   = (state == DRAIN) && m_ready;
    assign lane_end  = (lane == LW'(LANES - 1)) ||
                       (k_cur + CW'(1) >= n_len);
    assign grp_more  = (k0 + N_LANES) < n_len;
    assign acc_clr   = (state == LOAD) || (out_acc && lane_end);

    // State register.
    always_ff @(posedge clk) begin
        if (!n_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_ok) state_nx = LOAD;
            LOAD:    if (load_last) state_nx = COMPUTE;
            COMPUTE: if (n_last) state_nx = FLUSH;
            FLUSH:   state_nx = DRAIN;
            DRAIN: begin
                if (out_acc && lane_end) begin
                    state_nx = grp_more ? COMPUTE : FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sample buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (s_acc) begin
            mem[wr_idx] <= s_data;
        end
    end

    // Counters, operand pipeline and rejection pulse.
    always_ff @(posedge clk) begin
        if (!n_Reset) begin
            n_len  <= '0;
            k0     <= '0;
            wr_idx <= '0;
            n_idx  <= '0;
            lane   <= '0;
            rej_q  <= 1'b0;
            mac_en <= 1'b0;
            x_q    <= '0;
            tw_q   <= '0;
        end else begin
            rej_q  <= (state == IDLE) && start && !start_ok;
            mac_en <= (state == COMPUTE);
            if (state == IDLE && start_ok) begin
                n_len  <= samp_number;
                wr_idx <= '0;
            end
            if (s_acc) begin
                wr_idx <= wr_idx + ADDR_W'(1);
            end
            if (load_last) begin
                n_idx <= '0;
                k0    <= '0;
            end
            if (state == COMPUTE) begin
                x_q   <= mem[n_idx];
                tw_q  <= tw_data;
                n_idx <= n_idx + ADDR_W'(1);
            end
            if (state == FLUSH) begin
                lane <= '0;
            end
            if (out_acc) begin
                if (lane_end) begin
                    lane  <= '0;
                    n_idx <= '0;
                    k0    <= k0 + N_LANES;
                end else begin
                    lane <= lane + LW'(1);
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int RO = re_off(l, DATA_W);
        localparam int IO = im_off(l, DATA_W);

        dft_lane #(
            .DATA_W(DATA_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .n_Reset(n_Reset),
            .clr    (acc_clr),
            .ce     (mac_en),
            .x      (x_q),
            .tw_re  (tw_q[RO +: DATA_W]),
            .tw_im  (tw_q[IO +: DATA_W]),
            .acc_re (acc_re[l]),
            .acc_im (acc_im[l])
        );

        assign tw_k_idx[l*ADDR_W +: ADDR_W] = (state == COMPUTE) ?
            ADDR_W'(k0 + CW'(l)) : '0;
    end

    // Status and output stream, zeroed outside DRAIN.
    always_comb begin
        s_ready  = (state == LOAD);
        busy     = (state != IDLE);
        done     = (state == FINISH) || rej_q;
        err      = rej_q;
        m_valid  = (state == DRAIN);
        tw_n_idx = (state == COMPUTE) ? n_idx : '0;
        o_re     = '0;
        o_im     = '0;
        m_data   = '0;
        m_bin    = '0;
        if (m_valid) begin
            o_re   = sat(64'(acc_re[lane]), DATA_W);
            o_im   = sat(64'(acc_im[lane]), DATA_W);
            m_data = {o_re[DATA_W-1:0], o_im[DATA_W-1:0]};
            m_bin  = k_cur[ADDR_W-1:0];
        end
    end

endmodule
